// File: rtl/execute_ldst_responder_pkg.sv
// rtl/execute_ldst_responder_pkg.sv - LDST order codes, FSM states, request record and helpers
package execute_ldst_responder_pkg;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'd0,
    ORDER_HALF = 2'd1,
    ORDER_WORD = 2'd2
  } ldst_order_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } ldst_state_e;

  typedef struct packed {
    logic        rw;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic [1:0]  shift;
  } ldst_req_t;

  localparam int LDST_REQ_W = $bits(ldst_req_t);

  // Shift the addressed lane down to bit 0, then zero-extend to the access size.
  function automatic logic [31:0] load_align(input logic [31:0] raw, input logic [1:0] order,
                                             input logic [1:0] shift);
    logic [31:0] w;
    w = raw >> {shift, 3'b000};
    case (order)
      ORDER_BYTE: return {24'h0, w[7:0]};
      ORDER_HALF: return {16'h0, w[15:0]};
      default:    return w;
    endcase
  endfunction

  function automatic logic align_fault(input logic [1:0] order, input logic [1:0] addr_lo,
                                       input logic [3:0] mask);
    return ((order == ORDER_HALF) && addr_lo[0]) ||
           ((order == ORDER_WORD) && (addr_lo != 2'b00)) ||
           (mask == 4'b0000);
  endfunction

endpackage

// File: rtl/execute_ldst_req_fifo.sv
// rtl/execute_ldst_req_fifo.sv - LDST request buffer with flush; count is DEPTH_N+1 bits wide
module execute_ldst_req_fifo
  import execute_ldst_responder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int DEPTH_N = 1,
  parameter int W       = LDST_REQ_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           push,
  input  logic [W-1:0]   push_data,
  input  logic           pop,
  output logic [W-1:0]   head,
  output logic [DEPTH_N:0] count,
  output logic           empty
);

  logic [W-1:0]         mem [DEPTH];
  logic [DEPTH_N-1:0]   wr_ptr;
  logic [DEPTH_N-1:0]   rd_ptr;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (DEPTH_N + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/execute_ldst_responder.sv
// rtl/execute_ldst_responder.sv - LDST buffer, memory issue FSM and load return; LDST_ALIGN_FAULT_EN adds alignment faults
module execute_ldst_responder
  import execute_ldst_responder_pkg::*;
#(
  parameter int P_FIFO_DEPTH   = 2,
  parameter int P_FIFO_DEPTH_N = 1
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iFLUSH,
  input  logic        iLDST_REQ,
  output logic        oLDST_BUSY,
  input  logic        iLDST_RW,
  input  logic [31:0] iLDST_PDT,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  input  logic [1:0]  iLDST_ORDER,
  input  logic [3:0]  iLDST_MASK,
  input  logic [1:0]  iLOAD_SHIFT,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_PDT,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  output logic [1:0]  oMEM_ORDER,
  output logic [3:0]  oMEM_MASK,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  output logic        oWB_VALID,
  output logic        oWB_RW,
  output logic [31:0] oWB_DATA,
  output logic        oWB_FAULT
);

  localparam int CNT_W = P_FIFO_DEPTH_N + 1;

  ldst_state_e        state;
  ldst_req_t          req;
  ldst_req_t          push_req;
  ldst_req_t          head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               head_fault;

  assign push_req = '{rw: iLDST_RW, pdt: iLDST_PDT, addr: iLDST_ADDR, data: iLDST_DATA,
                      order: iLDST_ORDER, mask: iLDST_MASK, shift: iLOAD_SHIFT};

  assign oLDST_BUSY = (fifo_count == CNT_W'(P_FIFO_DEPTH)) || (state == ST_DRAIN);
  assign fifo_push  = iLDST_REQ && !oLDST_BUSY && !iFLUSH;

`ifdef LDST_ALIGN_FAULT_EN
  assign head_fault = align_fault(head.order, head.addr[1:0], head.mask);
`else
  assign head_fault = 1'b0;
`endif

  // A faulting head is popped from IDLE without issue; WAIT only chains directly into clean requests.
  assign fifo_pop = !iFLUSH && !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_WAIT) && iMEM_VALID && !head_fault));

  execute_ldst_req_fifo #(
    .DEPTH   (P_FIFO_DEPTH),
    .DEPTH_N (P_FIFO_DEPTH_N),
    .W       (LDST_REQ_W)
  ) u_fifo (
    .clk       (iCLOCK),
    .rst       (iRESET),
    .flush     (iFLUSH),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign oMEM_RW    = req.rw;
  assign oMEM_PDT   = req.pdt;
  assign oMEM_ADDR  = req.addr;
  assign oMEM_DATA  = req.data;
  assign oMEM_ORDER = req.order;
  assign oMEM_MASK  = req.mask;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state     <= ST_IDLE;
      req       <= '0;
      oMEM_REQ  <= 1'b0;
      oWB_VALID <= 1'b0;
      oWB_RW    <= 1'b0;
      oWB_DATA  <= 32'h0;
      oWB_FAULT <= 1'b0;
    end else begin
      oWB_VALID <= 1'b0;
      oWB_RW    <= 1'b0;
      oWB_DATA  <= 32'h0;
      oWB_FAULT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!iFLUSH && !fifo_empty) begin
            if (head_fault) begin
              oWB_VALID <= 1'b1;
              oWB_RW    <= head.rw;
              oWB_FAULT <= 1'b1;
            end else begin
              req      <= head;
              oMEM_REQ <= 1'b1;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (iFLUSH || !iMEM_LOCK) begin
            oMEM_REQ <= 1'b0;
            state    <= iFLUSH ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A completion arriving with the flush is dropped; there is then nothing left to drain.
          if (iFLUSH) begin
            state <= iMEM_VALID ? ST_IDLE : ST_DRAIN;
          end else if (iMEM_VALID) begin
            oWB_VALID <= 1'b1;
            oWB_RW    <= req.rw;
            oWB_DATA  <= req.rw ? 32'h0 : load_align(iMEM_DATA, req.order, req.shift);
            if (!fifo_empty && !head_fault) begin
              req      <= head;
              oMEM_REQ <= 1'b1;
              state    <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (iMEM_VALID) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_ldst_responder.sv
// tb/tb_execute_ldst_responder.sv - directed self-checking bench for execute_ldst_responder
module tb_execute_ldst_responder;

  logic        clk, rst, flush, ldst_req, ldst_busy, ldst_rw;
  logic [31:0] ldst_pdt, ldst_addr, ldst_data;
  logic [1:0]  ldst_order, load_shift;
  logic [3:0]  ldst_mask;
  logic        mem_req, mem_lock, mem_rw, mem_valid;
  logic [31:0] mem_pdt, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_order;
  logic [3:0]  mem_mask;
  logic        wb_valid, wb_rw, wb_fault;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  execute_ldst_responder dut (
    .iCLOCK(clk), .iRESET(rst), .iFLUSH(flush), .iLDST_REQ(ldst_req), .oLDST_BUSY(ldst_busy),
    .iLDST_RW(ldst_rw), .iLDST_PDT(ldst_pdt), .iLDST_ADDR(ldst_addr), .iLDST_DATA(ldst_data),
    .iLDST_ORDER(ldst_order), .iLDST_MASK(ldst_mask), .iLOAD_SHIFT(load_shift),
    .oMEM_REQ(mem_req), .iMEM_LOCK(mem_lock), .oMEM_RW(mem_rw), .oMEM_PDT(mem_pdt),
    .oMEM_ADDR(mem_addr), .oMEM_DATA(mem_wdata), .oMEM_ORDER(mem_order), .oMEM_MASK(mem_mask),
    .iMEM_VALID(mem_valid), .iMEM_DATA(mem_rdata),
    .oWB_VALID(wb_valid), .oWB_RW(wb_rw), .oWB_DATA(wb_data), .oWB_FAULT(wb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_req(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] order, input logic [3:0] mask, input logic [1:0] shift);
    ldst_req = 1'b1; ldst_rw = rw; ldst_addr = addr; ldst_data = data;
    ldst_order = order; ldst_mask = mask; load_shift = shift;
    @(negedge clk);
    ldst_req = 1'b0;
  endtask

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 0; ldst_req = 0; ldst_rw = 0; ldst_pdt = 0; ldst_addr = 0; ldst_data = 0;
    ldst_order = 0; ldst_mask = 0; load_shift = 0; mem_lock = 0; mem_valid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (ldst_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ldst_busy); end
    total++; if (wb_valid !== 1'b0 || wb_fault !== 1'b0) begin bad++; $display("FAIL reset_wb got=%b/%b exp=0/0", wb_valid, wb_fault); end
    total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_fields got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte;
    ldst_pdt = 32'h0000_A000;
    send_req(1'b0, 32'h103, 32'h0, 2'd0, 4'b1000, 2'd3);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lb_req_early got=%b exp=0", mem_req); end
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h103 || mem_rw !== 1'b0) begin bad++; $display("FAIL lb_issue got=%b/%h/%b exp=1/103/0", mem_req, mem_addr, mem_rw); end
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lb_req_fall got=%b exp=0", mem_req); end
    mem_valid = 1'b1; mem_rdata = 32'hAABBCCDD;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_00AA || wb_rw !== 1'b0) begin bad++; $display("FAIL lb_wb got=%b/%h/%b exp=1/000000aa/0", wb_valid, wb_data, wb_rw); end
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lb_wb_pulse got=%b exp=0", wb_valid); end
  endtask

  task automatic test_load_align;
    logic [31:0] addrs [5] = '{32'h202, 32'h300, 32'h101, 32'h400, 32'h100};
    logic [1:0]  ords  [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [1:0]  shs   [5] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [31:0] raws  [5] = '{32'h12345678, 32'h12345678, 32'h11223344, 32'hCAFEBABE, 32'h000000F0};
    logic [31:0] exps  [5] = '{32'h00001234, 32'h12345678, 32'h00000033, 32'h0000BABE, 32'h000000F0};
    bit ok;
    for (int i = 0; i < 5; i++) begin
      send_req(1'b0, addrs[i], 32'h0, ords[i], 4'hF, shs[i]);
      wait_mem_req(ok);
      total++; if (!ok || mem_addr !== addrs[i]) begin bad++; $display("FAIL align%0d_issue got=%b/%h exp=1/%h", i, ok, mem_addr, addrs[i]); end
      @(negedge clk);
      mem_valid = 1'b1; mem_rdata = raws[i];
      @(negedge clk);
      mem_valid = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb_data !== exps[i] || wb_rw !== 1'b0) begin bad++; $display("FAIL align%0d_wb got=%b/%h exp=1/%h", i, wb_valid, wb_data, exps[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_store_lock;
    int cnt = 0;
    bit stable = 1'b1;
    mem_lock = 1'b1; ldst_pdt = 32'h1234_5000;
    send_req(1'b1, 32'h500, 32'hDEADBEEF, 2'd2, 4'hF, 2'd0);
    for (int i = 0; i < 30; i++) begin
      if (mem_req) begin
        cnt++;
        if (mem_rw !== 1'b1 || mem_addr !== 32'h500 || mem_wdata !== 32'hDEADBEEF || mem_pdt !== 32'h1234_5000 ||
            mem_order !== 2'd2 || mem_mask !== 4'hF) stable = 1'b0;
        if (cnt == 6) mem_lock = 1'b0;
      end else if (cnt > 0) break;
      @(negedge clk);
    end
    mem_lock = 1'b0;
    total++; if (cnt != 6) begin bad++; $display("FAIL lock_req_cycles got=%0d exp=6", cnt); end
    total++; if (!stable) begin bad++; $display("FAIL lock_fields_stable got=0 exp=1"); end
    mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_rw !== 1'b1 || wb_data !== 32'h0) begin bad++; $display("FAIL store_wb got=%b/%b/%h exp=1/1/0", wb_valid, wb_rw, wb_data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    send_req(1'b0, 32'h10, 32'h0, 2'd2, 4'hF, 2'd0);
    total++; if (ldst_busy !== 1'b0) begin bad++; $display("FAIL bp_busy1 got=%b exp=0", ldst_busy); end
    send_req(1'b0, 32'h20, 32'h0, 2'd2, 4'hF, 2'd0);
    total++; if (ldst_busy !== 1'b0) begin bad++; $display("FAIL bp_busy2 got=%b exp=0", ldst_busy); end
    send_req(1'b0, 32'h30, 32'h0, 2'd2, 4'hF, 2'd0);
    total++; if (ldst_busy !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h10) begin bad++; $display("FAIL bp_full got=%b/%b/%h exp=1/0/10", ldst_busy, mem_req, mem_addr); end
    @(negedge clk);
    total++; if (ldst_busy !== 1'b1) begin bad++; $display("FAIL bp_busy_hold got=%b exp=1", ldst_busy); end
    mem_valid = 1'b1; mem_rdata = 32'hA000_0010;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hA000_0010) begin bad++; $display("FAIL bp_wb_a got=%b/%h exp=1/a0000010", wb_valid, wb_data); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || ldst_busy !== 1'b0) begin bad++; $display("FAIL bp_issue_b got=%b/%h/%b exp=1/20/0", mem_req, mem_addr, ldst_busy); end
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 32'hB000_0020;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hB000_0020 || mem_addr !== 32'h30 || mem_req !== 1'b1) begin bad++; $display("FAIL bp_wb_b got=%b/%h/%h exp=1/b0000020/30", wb_valid, wb_data, mem_addr); end
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 32'hC000_0030;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hC000_0030 || mem_req !== 1'b0 || ldst_busy !== 1'b0) begin bad++; $display("FAIL bp_wb_c got=%b/%h/%b/%b exp=1/c0000030/0/0", wb_valid, wb_data, mem_req, ldst_busy); end
    @(negedge clk);
  endtask

  task automatic test_flush_wait;
    int seen = 0;
    bit ok;
    send_req(1'b0, 32'h600, 32'h0, 2'd2, 4'hF, 2'd0);
    send_req(1'b0, 32'h610, 32'h0, 2'd2, 4'hF, 2'd0);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin bad++; $display("FAIL fw_issue got=%b/%h exp=1/600", mem_req, mem_addr); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (ldst_busy !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL fw_drain got=%b/%b exp=1/0", ldst_busy, mem_req); end
    mem_valid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (wb_valid !== 1'b0 || ldst_busy !== 1'b0) begin bad++; $display("FAIL fw_no_wb got=%b/%b exp=0/0", wb_valid, ldst_busy); end
    for (int i = 0; i < 4; i++) begin
      if (mem_req) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL fw_fifo_empty got=%0d exp=0", seen); end
    send_req(1'b0, 32'h700, 32'h0, 2'd2, 4'hF, 2'd0);
    wait_mem_req(ok);
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 32'h5566_7788;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (!ok || wb_valid !== 1'b1 || wb_data !== 32'h5566_7788) begin bad++; $display("FAIL fw_next got=%b/%b/%h exp=1/1/55667788", ok, wb_valid, wb_data); end
    @(negedge clk);
  endtask

  task automatic test_flush_issue;
    int seen = 0;
    bit ok;
    mem_lock = 1'b1;
    send_req(1'b0, 32'h800, 32'h0, 2'd2, 4'hF, 2'd0);
    wait_mem_req(ok);
    flush = 1'b1; ldst_req = 1'b1; ldst_addr = 32'h900;
    @(negedge clk);
    flush = 1'b0; ldst_req = 1'b0; mem_lock = 1'b0;
    total++; if (!ok || mem_req !== 1'b0) begin bad++; $display("FAIL fi_drop got=%b/%b exp=1/0", ok, mem_req); end
    for (int i = 0; i < 5; i++) begin
      if (mem_req || wb_valid) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL fi_req_discarded got=%0d exp=0", seen); end
  endtask

  task automatic test_stray_valid;
    mem_valid = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL stray_valid got=%b/%b exp=0/0", wb_valid, mem_req); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    send_req(1'b1, 32'hA00, 32'h3333_3333, 2'd2, 4'hF, 2'd0);
    wait_mem_req(ok);
    #2 rst = 1'b1;
    #1;
    total++; if (!ok || mem_req !== 1'b0 || mem_addr !== 32'h0 || ldst_busy !== 1'b0) begin bad++; $display("FAIL reset_mid got=%b/%b/%h/%b exp=1/0/0/0", ok, mem_req, mem_addr, ldst_busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_quiet got=%b/%b exp=0/0", mem_req, wb_valid); end
  endtask

`ifdef LDST_ALIGN_FAULT_EN
  task automatic test_fault;
    int reqs = 0;
    int faults = 0;
    send_req(1'b0, 32'h101, 32'h0, 2'd2, 4'hF, 2'd0);
    for (int i = 0; i < 6; i++) begin
      if (mem_req) reqs++;
      if (wb_valid && wb_fault && wb_data == 32'h0) faults++;
      @(negedge clk);
    end
    total++; if (reqs != 0 || faults != 1) begin bad++; $display("FAIL fault got=%0d/%0d exp=0/1", reqs, faults); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_byte();
    test_load_align();
    test_store_lock();
    test_back_to_back();
    test_flush_wait();
    test_flush_issue();
    test_stray_valid();
`ifdef LDST_ALIGN_FAULT_EN
    test_fault();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
